// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU: op encoding and FSM states.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    NOR  = 4'd5,
    SLT  = 4'd6,
    SLTU = 4'd7,
    SLL  = 4'd8,
    SRL  = 4'd9,
    SRA  = 4'd10,
    MULU = 4'd11,
    DIVU = 4'd12
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the EX-stage control and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;
  logic             div_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result_lo, result_hi, zero, overflow, div_zero, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result_lo, result_hi, zero, overflow, div_zero, busy, done
  );

endinterface

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one 2*WIDTH register.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      count;
  logic               div_mode;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   trial;

  // The upper half is the partial product (MUL) or partial remainder (DIV);
  // the lower half holds the multiplier being consumed or the quotient being built.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shl     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial   = shl[WIDTH-1:0] - opnd;
    acc_nxt = acc;
    if (div_mode) begin
      if (shl >= {1'b0, opnd}) begin
        acc_nxt = {trial, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      end else begin
        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

  // fin flags the edge that performs the last step, so the owner can load
  // the finished value on that same edge from hi/lo.
  assign fin = (count == CW'(1));
  assign hi  = acc_nxt[2*WIDTH-1:WIDTH];
  assign lo  = acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      opnd     <= '0;
      count    <= '0;
      div_mode <= 1'b0;
    end else if (go) begin
      acc      <= {{WIDTH{1'b0}}, a};
      opnd     <= b;
      count    <= CW'(WIDTH);
      div_mode <= is_div;
    end else if (count != '0) begin
      acc   <= acc_nxt;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle datapath, registered outputs and the
// start/busy/done sequencing around the iterative multiply/divide unit.
//
//   state | meaning
//   IDLE  | ready; single-cycle ops and DIVU-by-zero complete from here
//   MUL   | shift-add multiply stepping, one bit per cycle
//   DIV   | restoring divide stepping, one bit per cycle
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);

  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SW-1:0]    shamt;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ovf;
  logic             sc_dz;

  logic             accept;
  logic             long_op;
  logic             go;
  logic             md_fin;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  state_t           state;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic             zero_r;
  logic             ovf_r;
  logic             dz_r;
  logic             busy_r;
  logic             done_r;

  assign op    = op_t'(bus.op);
  assign a     = bus.a;
  assign b     = bus.b;
  assign shamt = b[SW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dz  = 1'b0;
    case (op)
      ADD: begin
        sc_lo  = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        sc_lo  = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      AND:  sc_lo = a & b;
      OR:   sc_lo = a | b;
      XOR:  sc_lo = a ^ b;
      NOR:  sc_lo = ~(a | b);
      SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
      SLL:  sc_lo = a << shamt;
      SRL:  sc_lo = a >> shamt;
      SRA:  sc_lo = $unsigned($signed(a) >>> shamt);
      // Only reached with b == 0; a nonzero divisor takes the iterative path.
      DIVU: begin
        sc_lo = '1;
        sc_hi = a;
        sc_dz = 1'b1;
      end
      default: ;
    endcase
  end

  assign long_op = (op == MULU) || ((op == DIVU) && (b != '0));
  assign accept  = bus.start && !busy_r;
  assign go      = accept && long_op;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .is_div (op == DIVU),
    .a      (a),
    .b      (b),
    .fin    (md_fin),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lo_r   <= '0;
      hi_r   <= '0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
      dz_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && long_op) begin
            state  <= (op == MULU) ? MUL : DIV;
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end else if (accept) begin
            lo_r   <= sc_lo;
            hi_r   <= sc_hi;
            zero_r <= (sc_lo == '0);
            ovf_r  <= sc_ovf;
            dz_r   <= sc_dz;
            done_r <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        MUL, DIV: begin
          if (md_fin) begin
            state  <= IDLE;
            lo_r   <= md_lo;
            hi_r   <= md_hi;
            zero_r <= (md_lo == '0);
            ovf_r  <= 1'b0;
            dz_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_lo = lo_r;
  assign bus.result_hi = hi_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = ovf_r;
  assign bus.div_zero  = dz_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: scoreboard of expected completions popped on done.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = $clog2(W);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    logic         dz;
    int unsigned  cyc;
    string        name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [2*W-1:0] p;
    logic [SW-1:0]  sh;
    sh     = b[SW-1:0];
    e.lo   = '0;
    e.hi   = '0;
    e.ov   = 1'b0;
    e.dz   = 1'b0;
    e.cyc  = 0;
    e.name = "";
    case (op)
      4'd0: begin
        e.lo = a + b;
        e.ov = (a[W-1] == b[W-1]) && (e.lo[W-1] != a[W-1]);
      end
      4'd1: begin
        e.lo = a - b;
        e.ov = (a[W-1] != b[W-1]) && (e.lo[W-1] != a[W-1]);
      end
      4'd2:  e.lo = a & b;
      4'd3:  e.lo = a | b;
      4'd4:  e.lo = a ^ b;
      4'd5:  e.lo = ~(a | b);
      4'd6:  e.lo = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd7:  e.lo = (a < b) ? 1 : 0;
      4'd8:  e.lo = a << sh;
      4'd9:  e.lo = a >> sh;
      4'd10: e.lo = $unsigned($signed(a) >>> sh);
      4'd11: begin
        p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
      end
      4'd12: begin
        if (b == '0) begin
          e.lo = '1;
          e.hi = a;
          e.dz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: ;
    endcase
    e.z = (e.lo == '0);
    return e;
  endfunction

  function automatic void push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int unsigned t, input string name);
    exp_t e;
    e      = model(op, a, b);
    e.cyc  = t + 1 + (((op == 4'd11) || ((op == 4'd12) && (b != '0))) ? W : 0);
    e.name = name;
    sb.push_back(e);
  endfunction

  // Completion monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        n_tests++;
        if ({bus.result_lo, bus.result_hi} !== {mon_e.lo, mon_e.hi}) begin
          n_fail++;
          $display("FAIL %s result: lo=%h hi=%h, required lo=%h hi=%h",
                   mon_e.name, bus.result_lo, bus.result_hi, mon_e.lo, mon_e.hi);
        end
        n_tests++;
        if ({bus.zero, bus.overflow, bus.div_zero} !== {mon_e.z, mon_e.ov, mon_e.dz}) begin
          n_fail++;
          $display("FAIL %s flags: z/ov/dz=%b%b%b, required %b%b%b", mon_e.name,
                   bus.zero, bus.overflow, bus.div_zero, mon_e.z, mon_e.ov, mon_e.dz);
        end
        n_tests++;
        if (cyc !== mon_e.cyc || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s timing: done at cycle %0d busy=%b, required cycle %0d busy=0",
                   mon_e.name, cyc, bus.busy, mon_e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string name, output int unsigned t);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    t         = cyc;
    @(posedge clk);
    push_exp(op, a, b, t, name);
  endtask

  task automatic release_start();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s drain: %0d completions outstanding after %0d cycles, required 0",
               name, sb.size(), max_cyc);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.result_lo, bus.result_hi} !== {W{2'b00}}) begin
      n_fail++;
      $display("FAIL reset_results: lo=%h hi=%h, required 0", bus.result_lo, bus.result_hi);
    end
    n_tests++;
    if ({bus.zero, bus.overflow, bus.div_zero, bus.busy, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: z/ov/dz/busy/done=%b%b%b%b%b, required 00000",
               bus.zero, bus.overflow, bus.div_zero, bus.busy, bus.done);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_with_start: done=%b, required 0", bus.done);
    end
  endtask

  task automatic test_add_overflow();
    int unsigned t;
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf", t);
    release_start();
    n_tests++;
    if (bus.done !== 1'b1 || bus.result_lo !== 32'h8000_0000 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ovf_const: done=%b lo=%h ov=%b z=%b, required 1 80000000 1 0",
               bus.done, bus.result_lo, bus.overflow, bus.zero);
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ovf_single_pulse: done=%b, required 0", bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned t;
    issue(4'd1, 32'd5, 32'd5, "sub_zero", t);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, "slt", t);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, "sltu", t);
    issue(4'd1, 32'h8000_0000, 32'd1, "sub_ovf", t);
    issue(4'd5, 32'h0F0F_0000, 32'h0000_F0F0, "nor", t);
    release_start();
    drain("back_to_back", 8);
  endtask

  task automatic test_mulu_max();
    int unsigned t;
    int unsigned t2;
    int          busy_cnt;
    busy_cnt = 0;
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max", t);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.op    = 4'($urandom_range(0, 15));
      if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cnt++;
    end
    n_tests++;
    if (busy_cnt != W) begin
      n_fail++;
      $display("FAIL mulu_busy_len: busy cycles=%0d, required %0d", busy_cnt, W);
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1 || bus.result_hi !== 32'hFFFF_FFFE || bus.result_lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL mulu_max_const: done=%b hi=%h lo=%h, required 1 FFFFFFFE 00000001",
               bus.done, bus.result_hi, bus.result_lo);
    end
    // Issue while done is high: must be accepted on that very edge.
    bus.start = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    t2        = cyc;
    @(posedge clk);
    push_exp(4'd0, 32'd5, 32'd6, t2, "add_after_done");
    release_start();
    drain("mulu_max", 4);
  endtask

  task automatic test_divu();
    int unsigned t;
    issue(4'd12, 32'd100, 32'd7, "divu_100_7", t);
    release_start();
    drain("divu_100_7", W + 4);
    n_tests++;
    if (bus.result_lo !== 32'd14 || bus.result_hi !== 32'd2 || bus.div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_100_7_const: lo=%0d hi=%0d dz=%b, required 14 2 0",
               bus.result_lo, bus.result_hi, bus.div_zero);
    end
    issue(4'd12, 32'h0000_1234, 32'd0, "divu_by_zero", t);
    release_start();
    n_tests++;
    if (bus.result_lo !== 32'hFFFF_FFFF || bus.result_hi !== 32'h0000_1234 || bus.div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL divu_zero_const: lo=%h hi=%h dz=%b, required FFFFFFFF 00001234 1",
               bus.result_lo, bus.result_hi, bus.div_zero);
    end
    issue(4'd3, 32'h0000_00F0, 32'h0000_000F, "or_clears_dz", t);
    release_start();
    drain("divu", 4);
  endtask

  task automatic test_ignored_start();
    int unsigned t;
    issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, "mulu_ignore", t);
    release_start();
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 32'd1;
    bus.b     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start: busy=%b done=%b at cycle %0d, required 1 0", bus.busy, bus.done, cyc);
    end
    drain("ignored_start", W + 4);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int unsigned t;
    issue(4'd0, 32'd3, 32'd4, "add_before_abort", t);
    issue(4'd12, 32'hDEAD_BEEF, 32'd3, "divu_abort", t);
    release_start();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({bus.result_lo, bus.result_hi} !== {W{2'b00}} ||
        {bus.zero, bus.overflow, bus.div_zero, bus.busy, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: lo=%h hi=%h z/ov/dz/busy/done=%b%b%b%b%b, required all 0",
               bus.result_lo, bus.result_hi, bus.zero, bus.overflow, bus.div_zero, bus.busy, bus.done);
    end
    repeat (W + 2) @(negedge clk);
    issue(4'd10, 32'h8000_0000, 32'd4, "sra_after_reset", t);
    release_start();
    n_tests++;
    if (bus.done !== 1'b1 || bus.result_lo !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL sra_after_reset_const: done=%b lo=%h, required 1 F8000000", bus.done, bus.result_lo);
    end
    drain("reset_mid", 4);
  endtask

  task automatic test_random();
    int unsigned  t;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (op == 4'd12 && $urandom_range(0, 2) == 0) b = '0;
      if (op == 4'd12 && $urandom_range(0, 1) == 0) b = b >> $urandom_range(8, 28);
      issue(op, a, b, "random", t);
      if (op == 4'd11 || (op == 4'd12 && b != '0)) begin
        release_start();
        drain("random_long", W + 4);
      end
    end
    release_start();
    drain("random", 4);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_mulu_max();
    test_divu();
    test_ignored_start();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
